pipeline_ctrl: RTL and testbench
================================

Name: pipeline_ctrl

Overview:
Central stall/flush sequencer for the 5-stage RV32 pipeline (F, D, E, M, W). It merges three kinds of event into per-stage enable and flush controls:
- load-use hazards, detected in D against E;
- multi-cycle execute operations (mul/div), which hold E for a programmable latency;
- data-memory wait states in M.

It also redirects branch mispredicts and keeps a saturating stall-cycle performance counter. It sits beside the forwarding logic and drives the pipeline-register enables and clears directly.

Parameters:
WIDTH, 5, register address width
LAT_W, 6, width of the multi-cycle latency field and counter
PERF_W, 32, width of the stall performance counter

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
Rs1D  input  WIDTH  source register 1 of the instruction in D
Rs2D  input  WIDTH  source register 2 of the instruction in D
RdE  input  WIDTH  destination register of the instruction in E
MemReadE  input  1  instruction in E is a load
MultiCycleE  input  1  instruction in E is a multi-cycle op
LatencyE  input  LAT_W  total E-stage cycles required by that op
MemWaitM  input  1  data memory not ready for the access in M
flushBranch  input  1  branch/jump in E mispredicted
StallF  output  1  hold PC
StallD  output  1  hold F/D register
StallE  output  1  hold D/E register
StallM  output  1  hold E/M register
FlushD  output  1  clear F/D register to NOP
FlushE  output  1  clear D/E register to NOP
FlushM  output  1  clear E/M register to NOP
FlushW  output  1  clear M/W register to NOP
busy  output  1  multi-cycle op in progress
stall_count  output  PERF_W  cycles in which StallF was high, saturating

Behaviour:
- Reset state:
  - FSM state IDLE, cnt = 0, stall_count = 0.
  - While rst is high, all Stall*, Flush* and busy outputs are 0.
  - rst mid-operation abandons the op in one cycle, with no residual stall.
- FSM states: IDLE and MC_BUSY. cnt is LAT_W bits wide.
- Priority, highest first: MemWaitM > multi-cycle (entry or MC_BUSY) > flushBranch > load-use.
- MemWaitM = 1, in any state:
  - StallF, StallD, StallE and StallM = 1; FlushW = 1; all other flushes 0.
  - FSM state and cnt are frozen.
  - flushBranch and load-use are ignored that cycle; E is held, so they re-evaluate on the next cycle.
- Multi-cycle entry, when state is IDLE, MultiCycleE = 1, LatencyE = N >= 2 and MemWaitM = 0:
  - StallF, StallD and StallE = 1; FlushM = 1; busy = 1.
  - cnt <= N-2; next state MC_BUSY.
- LatencyE of 0 or 1: treated as a single-cycle op; no stall, no state change.
- MC_BUSY with cnt != 0: StallF, StallD and StallE = 1; FlushM = 1; busy = 1; cnt <= cnt-1.
- MC_BUSY with cnt == 0 (release cycle):
  - No stall; busy = 0; next state IDLE.
  - MultiCycleE still high from the departing op must not re-trigger entry.
- Cycle counts: an op with latency N holds E for exactly N cycles, and StallF is high for exactly N-1 of them (excluding MemWaitM cycles).
- flushBranch:
  - Sampled only in IDLE, and only when no entry occurs and MemWaitM = 0.
  - Response: FlushD = 1 and FlushE = 1, with all stalls 0.
  - Suppresses a simultaneous load-use stall.
  - Ignored in MC_BUSY, where E holds a mul/div op.
- Load-use, in IDLE with no higher-priority event:
  - Condition: MemReadE && RdE != 0 && (RdE == Rs1D || RdE == Rs2D).
  - Response: StallF = 1, StallD = 1, FlushE = 1.
  - Exactly one bubble, because the load advances to M on the next cycle.
- stall_count:
  - Increments by 1 on each cycle with StallF = 1 (rst low).
  - Holds at all-ones when saturated, with no wrap.
- All Stall/Flush outputs are combinational from FSM state, cnt and inputs; state, cnt and stall_count are registered.

Test Plan:
- Load-use: MemReadE = 1, RdE = 5, Rs1D = 5 for one cycle -> StallF = StallD = FlushE = 1 for that cycle only; stall_count = 1. Repeat with RdE = 0 -> no stall.
- Multi-cycle: MultiCycleE = 1, LatencyE = 4 -> StallF/StallD/StallE/FlushM = 1 and busy = 1 for 3 cycles, release on the 4th, back in IDLE. LatencyE = 1 -> no stall.
- Memory wait inside MC_BUSY: LatencyE = 5, MemWaitM high for 2 cycles at busy cycle 2 -> StallM = FlushW = 1 for those 2 cycles, cnt frozen, total busy stall cycles = 4 + 2.
- Branch vs. load-use: flushBranch = 1 with load-use true in the same cycle -> FlushD = FlushE = 1, StallF = 0. flushBranch during MC_BUSY -> ignored.
- Reset mid-op: LatencyE = 20, rst pulsed at busy cycle 3 -> next cycle state IDLE, busy = 0, stall_count = 0, all outputs 0.
- Saturation: preload stall_count = 0xFFFFFFFE (PERF_W = 32), then 3 stall cycles -> 0xFFFFFFFF and held.

Source files
------------

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall/flush sequencer for the 5-stage RV32 pipeline.
// Combines load-use hazards, multi-cycle execute ops and data-memory wait
// states into per-stage stall/flush controls, redirects branch mispredicts
// and keeps a saturating count of front-end stall cycles.
module pipeline_ctrl #(
  parameter int WIDTH  = 5,
  parameter int LAT_W  = 6,
  parameter int PERF_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  Rs1D,
  input  logic [WIDTH-1:0]  Rs2D,
  input  logic [WIDTH-1:0]  RdE,
  input  logic              MemReadE,
  input  logic              MultiCycleE,
  input  logic [LAT_W-1:0]  LatencyE,
  input  logic              MemWaitM,
  input  logic              flushBranch,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              StallM,
  output logic              FlushD,
  output logic              FlushE,
  output logic              FlushM,
  output logic              FlushW,
  output logic              busy,
  output logic [PERF_W-1:0] stall_count
);

  typedef enum logic {
    IDLE    = 1'b0,
    MC_BUSY = 1'b1
  } stateT;

  stateT            state;
  stateT            nextState;
  logic [LAT_W-1:0] cnt;
  logic [LAT_W-1:0] nextCnt;

  logic mcEntry;
  logic mcHold;
  logic loadUse;

  // Decode the events that compete for control of the pipeline this cycle
  always_comb begin
    mcEntry = (state == IDLE) && MultiCycleE && (LatencyE >= LAT_W'(2)) && !MemWaitM;
    mcHold  = (state == MC_BUSY) && (cnt != '0);
    loadUse = MemReadE && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D));
  end

  // State and remaining-cycle counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= nextState;
      cnt   <= nextCnt;
    end
  end

  // Next-state logic; a memory wait freezes the sequencer so the op resumes intact
  always_comb begin
    nextState = state;
    nextCnt   = cnt;
    if (!MemWaitM) begin
      case (state)
        IDLE: begin
          if (mcEntry) begin
            nextState = MC_BUSY;
            nextCnt   = LatencyE - LAT_W'(2);
          end
        end
        MC_BUSY: begin
          if (cnt != '0) begin
            nextCnt = cnt - LAT_W'(1);
          end else begin
            nextState = IDLE;
          end
        end
        default: begin
          nextState = IDLE;
          nextCnt   = '0;
        end
      endcase
    end
  end

  // Output decode in priority order: memory wait, multi-cycle, branch, load-use
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushM = 1'b0;
    FlushW = 1'b0;
    busy   = 1'b0;
    if (!rst) begin
      if (MemWaitM) begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
        FlushW = 1'b1;
        busy   = mcHold;
      end else if (mcEntry || mcHold) begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        FlushM = 1'b1;
        busy   = 1'b1;
      end else if (state == IDLE) begin
        if (flushBranch) begin
          FlushD = 1'b1;
          FlushE = 1'b1;
        end else if (loadUse) begin
          StallF = 1'b1;
          StallD = 1'b1;
          FlushE = 1'b1;
        end
      end
    end
  end

  // Saturating count of cycles in which the PC was held
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_count <= '0;
    end else if (StallF && (stall_count != '1)) begin
      stall_count <= stall_count + PERF_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: scoreboard bench for pipeline_ctrl. Each cycle's expected
// controls are queued when stimulus is driven and checked mid-cycle.
module tb_pipeline_ctrl;

  localparam logic [8:0] NONE = 9'b000000000;
  localparam logic [8:0] LU   = 9'b110001000;
  localparam logic [8:0] MC   = 9'b111000101;
  localparam logic [8:0] MWB  = 9'b111100011;
  localparam logic [8:0] MWI  = 9'b111100010;
  localparam logic [8:0] BR   = 9'b000011000;

  typedef struct {
    string       tag;
    logic [8:0]  ctl;
    logic [31:0] cnt;
    logic [1:0]  sat;
  } expT;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  Rs1D, Rs2D, RdE;
  logic        MemReadE, MultiCycleE;
  logic [5:0]  LatencyE;
  logic        MemWaitM, flushBranch;
  logic        StallF, StallD, StallE, StallM;
  logic        FlushD, FlushE, FlushM, FlushW, busy;
  logic [31:0] stall_count;
  logic        satStallF, satStallD, satStallE, satStallM;
  logic        satFlushD, satFlushE, satFlushM, satFlushW, satBusy;
  logic [1:0]  satCount;

  int          checkCount = 0;
  int          errorCount = 0;
  logic [31:0] expCount;
  logic [1:0]  expSat;
  expT         sbq[$];

  always #5 clk = ~clk;

  // Main instance with the full 32-bit performance counter
  pipeline_ctrl #(.WIDTH(5), .LAT_W(6), .PERF_W(32)) dut (
    .clk(clk), .rst(rst), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdE(RdE),
    .MemReadE(MemReadE), .MultiCycleE(MultiCycleE), .LatencyE(LatencyE),
    .MemWaitM(MemWaitM), .flushBranch(flushBranch),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM), .FlushW(FlushW),
    .busy(busy), .stall_count(stall_count)
  );

  // Narrow-counter instance so saturation is reached within a few stall cycles
  pipeline_ctrl #(.WIDTH(5), .LAT_W(6), .PERF_W(2)) dutSat (
    .clk(clk), .rst(rst), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdE(RdE),
    .MemReadE(MemReadE), .MultiCycleE(MultiCycleE), .LatencyE(LatencyE),
    .MemWaitM(MemWaitM), .flushBranch(flushBranch),
    .StallF(satStallF), .StallD(satStallD), .StallE(satStallE), .StallM(satStallM),
    .FlushD(satFlushD), .FlushE(satFlushE), .FlushM(satFlushM), .FlushW(satFlushW),
    .busy(satBusy), .stall_count(satCount)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [4:0] rd, input logic mr, input logic mc,
                               input logic [5:0] lat, input logic mw, input logic fb,
                               input logic [8:0] expCtl, input string tag);
    expT e;
    expT got;
    @(posedge clk);
    #1;
    rst         = r;
    Rs1D        = rs1;
    Rs2D        = rs2;
    RdE         = rd;
    MemReadE    = mr;
    MultiCycleE = mc;
    LatencyE    = lat;
    MemWaitM    = mw;
    flushBranch = fb;
    e.tag = tag;
    e.ctl = expCtl;
    e.cnt = expCount;
    e.sat = expSat;
    sbq.push_back(e);
    @(negedge clk);
    got = sbq.pop_front();
    checkOutput({got.tag, "/ctl"},
                {23'b0, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, FlushW, busy},
                {23'b0, got.ctl});
    checkOutput({got.tag, "/cnt"}, stall_count, got.cnt);
    checkOutput({got.tag, "/sat"}, {30'b0, satCount}, {30'b0, got.sat});
    if (r) begin
      expCount = '0;
      expSat   = '0;
    end else if (expCtl[8]) begin
      if (expCount != 32'hFFFFFFFF) expCount = expCount + 32'd1;
      if (expSat != 2'b11) expSat = expSat + 2'd1;
    end
  endtask

  initial begin
    rst = 1'b1; Rs1D = '0; Rs2D = '0; RdE = '0; MemReadE = 1'b0;
    MultiCycleE = 1'b0; LatencyE = '0; MemWaitM = 1'b0; flushBranch = 1'b0;
    expCount = '0;
    expSat   = '0;
    repeat (2) @(posedge clk);

    // reset gates every output even with active requests
    applyStimulus(1, 5, 0, 5, 1, 1, 4, 1, 1, NONE, "rst_gate");
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, NONE, "idle");

    // load-use on rs1, on rs2, and with x0 destination
    applyStimulus(0, 5, 0, 5, 1, 0, 0, 0, 0, LU,   "lu_rs1");
    applyStimulus(0, 5, 0, 6, 0, 0, 0, 0, 0, NONE, "lu_after");
    applyStimulus(0, 1, 7, 7, 1, 0, 0, 0, 0, LU,   "lu_rs2");
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 0, 0, NONE, "lu_x0");
    applyStimulus(0, 3, 4, 5, 0, 0, 0, 0, 0, NONE, "no_load");

    // latency 4: three stall cycles, release with MultiCycleE still high
    applyStimulus(0, 0, 0, 0, 0, 1, 4, 0, 0, MC,   "mc4_c1");
    applyStimulus(0, 0, 0, 0, 0, 1, 4, 0, 0, MC,   "mc4_c2");
    applyStimulus(0, 0, 0, 0, 0, 1, 4, 0, 0, MC,   "mc4_c3");
    applyStimulus(0, 0, 0, 0, 0, 1, 4, 0, 0, NONE, "mc4_rel");
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, NONE, "mc4_idle");

    // latencies 1 and 0 behave as single-cycle ops
    applyStimulus(0, 0, 0, 0, 0, 1, 1, 0, 0, NONE, "lat1");
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 0, 0, NONE, "lat0");

    // latency 5 with two memory-wait cycles at busy cycle 2
    applyStimulus(0, 0, 0, 0, 0, 1, 5, 0, 0, MC,   "mw_c1");
    applyStimulus(0, 0, 0, 0, 0, 1, 5, 1, 0, MWB,  "mw_w1");
    applyStimulus(0, 0, 0, 0, 0, 1, 5, 1, 0, MWB,  "mw_w2");
    applyStimulus(0, 0, 0, 0, 0, 1, 5, 0, 0, MC,   "mw_c2");
    applyStimulus(0, 0, 0, 0, 0, 1, 5, 0, 0, MC,   "mw_c3");
    applyStimulus(0, 0, 0, 0, 0, 1, 5, 0, 0, MC,   "mw_c4");
    applyStimulus(0, 0, 0, 0, 0, 1, 5, 0, 0, NONE, "mw_rel");

    // branch beats load-use; memory wait beats branch in IDLE
    applyStimulus(0, 5, 0, 5, 1, 0, 0, 0, 1, BR,   "br_lu");
    applyStimulus(0, 5, 0, 5, 1, 0, 0, 1, 1, MWI,  "mw_br");
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, BR,   "br_only");

    // branch ignored while busy and on the release cycle
    applyStimulus(0, 0, 0, 0, 0, 1, 3, 0, 0, MC,   "mcbr_c1");
    applyStimulus(0, 0, 0, 0, 0, 1, 3, 0, 1, MC,   "mcbr_c2");
    applyStimulus(0, 0, 0, 0, 0, 1, 3, 0, 1, NONE, "mcbr_rel");
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, NONE, "mcbr_idle");

    // reset at busy cycle 3 of a latency-20 op
    applyStimulus(0, 0, 0, 0, 0, 1, 20, 0, 0, MC,  "rmid_c1");
    applyStimulus(0, 0, 0, 0, 0, 1, 20, 0, 0, MC,  "rmid_c2");
    applyStimulus(1, 0, 0, 0, 0, 1, 20, 0, 0, NONE, "rmid_rst");
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, NONE, "rmid_idle");
    applyStimulus(0, 9, 0, 9, 1, 0, 0, 0, 0, LU,   "rmid_lu");

    // keep stalling to drive the narrow counter through saturation
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 2, 0, 2, 1, 0, 0, 0, 0, LU, $sformatf("sat_%0d", i));
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, NONE, "sat_hold");

    checkOutput("sbq_empty", sbq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
